// File: rtl/cajero_pkg.sv
// Shared types and default constants for the cash dispenser slice.
package cajero_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DISPENSE,
        GAP,
        DONE
    } disp_state_t;

    localparam int DEF_AMT_1    = 100;
    localparam int DEF_AMT_2    = 200;
    localparam int DEF_AMT_3    = 500;
    localparam int DEF_AMT_4    = 1000;
    localparam int DEF_AMT_5    = 2000;
    localparam int DEF_BILL_VAL = 100;
    localparam int DEF_BILL_GAP = 2;

endpackage

// File: rtl/contador_billetes.sv
// Bill pacer: holds the remaining-bill and inter-bill gap counters and
// produces the registered bill pulse. The parent FSM decides when to load,
// fire and tick the gap; this block only counts.
module contador_billetes #(
    parameter int CNT_W    = 16,
    parameter int BILL_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             fire,
    input  logic             gap_tick,
    output logic             billete,
    output logic             last_bill,
    output logic             gap_last
);

    localparam int GAP_W = (BILL_GAP < 2) ? 1 : $clog2(BILL_GAP + 1);

    logic [CNT_W-1:0] bills;
    logic [GAP_W-1:0] gap;

    // Counter updates and the bill pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bills   <= '0;
            gap     <= '0;
            billete <= 1'b0;
        end else begin
            billete <= fire;
            if (load) begin
                bills <= load_count;
            end else if (fire) begin
                bills <= bills - 1'b1;
            end
            if (fire) begin
                gap <= GAP_W'(BILL_GAP);
            end else if (gap_tick) begin
                gap <= gap - 1'b1;
            end
        end
    end

    // Firing with one bill left empties the counter; a gap of one expires now.
    assign last_bill = (bills == CNT_W'(1));
    assign gap_last  = (gap == GAP_W'(1));

endmodule

// File: rtl/cajero_dispensador.sv
// Withdrawal validator and cash dispenser: validates the selected amount
// against the balance, debits it and paces out bill pulses.
module cajero_dispensador
    import cajero_pkg::*;
#(
    parameter int BAL_W        = 16,
    parameter int INIT_BALANCE = 1000,
    parameter int AMT_1        = DEF_AMT_1,
    parameter int AMT_2        = DEF_AMT_2,
    parameter int AMT_3        = DEF_AMT_3,
    parameter int AMT_4        = DEF_AMT_4,
    parameter int AMT_5        = DEF_AMT_5,
    parameter int BILL_VAL     = DEF_BILL_VAL,
    parameter int BILL_GAP     = DEF_BILL_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             OPCION_1,
    input  logic             OPCION_2,
    input  logic             OPCION_3,
    input  logic             OPCION_4,
    input  logic             OPCION_5,
    input  logic             CARGAR,
    input  logic [BAL_W-1:0] SALDO_IN,
    output logic             VALIDO,
    output logic             INVALIDO,
    output logic             BILLETE,
    output logic             DISPENSANDO,
    output logic             LISTO,
    output logic [BAL_W-1:0] SALDO
);

    disp_state_t      state, state_d;
    logic [4:0]       opc;
    logic             req, req_q, req_edge;
    logic [BAL_W-1:0] amt_q, amt_d, cnt_q, cnt_d, saldo_d;
    logic [BAL_W-1:0] sel_amt, sel_cnt;
    logic             sel_ok;
    logic             valido_d, invalido_d, listo_d, disp_d;
    logic             load, fire, gap_tick, last_bill, gap_last;

    assign opc      = {OPCION_5, OPCION_4, OPCION_3, OPCION_2, OPCION_1};
    assign req      = |opc;
    assign req_edge = req & ~req_q;

    // Amount and bill count per option; the bill count is latched alongside
    // the amount so no runtime divider is needed.
    always_comb begin
        sel_ok  = 1'b1;
        sel_amt = '0;
        sel_cnt = '0;
        case (opc)
            5'b00001: begin sel_amt = BAL_W'(AMT_1); sel_cnt = BAL_W'(AMT_1 / BILL_VAL); end
            5'b00010: begin sel_amt = BAL_W'(AMT_2); sel_cnt = BAL_W'(AMT_2 / BILL_VAL); end
            5'b00100: begin sel_amt = BAL_W'(AMT_3); sel_cnt = BAL_W'(AMT_3 / BILL_VAL); end
            5'b01000: begin sel_amt = BAL_W'(AMT_4); sel_cnt = BAL_W'(AMT_4 / BILL_VAL); end
            5'b10000: begin sel_amt = BAL_W'(AMT_5); sel_cnt = BAL_W'(AMT_5 / BILL_VAL); end
            default:  sel_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state;
        amt_d      = amt_q;
        cnt_d      = cnt_q;
        saldo_d    = SALDO;
        valido_d   = 1'b0;
        invalido_d = 1'b0;
        listo_d    = 1'b0;
        disp_d     = DISPENSANDO;
        load       = 1'b0;
        fire       = 1'b0;
        gap_tick   = 1'b0;
        case (state)
            IDLE: begin
                if (req_edge) begin
                    if (sel_ok) begin
                        amt_d   = sel_amt;
                        cnt_d   = sel_cnt;
                        state_d = CHECK;
                    end else begin
                        invalido_d = 1'b1;
                    end
                end else if (CARGAR) begin
                    saldo_d = SALDO_IN;
                end
            end
            CHECK: begin
                if (amt_q <= SALDO) begin
                    valido_d = 1'b1;
                    saldo_d  = SALDO - amt_q;
                    load     = 1'b1;
                    disp_d   = 1'b1;
                    state_d  = DISPENSE;
                end else begin
                    invalido_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            DISPENSE: begin
                fire = 1'b1;
                if (last_bill) begin
                    state_d = DONE;
                end else if (BILL_GAP == 0) begin
                    state_d = DISPENSE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_tick = 1'b1;
                if (gap_last) begin
                    state_d = DISPENSE;
                end
            end
            DONE: begin
                listo_d = 1'b1;
                disp_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            amt_q       <= '0;
            cnt_q       <= '0;
            SALDO       <= BAL_W'(INIT_BALANCE);
            VALIDO      <= 1'b0;
            INVALIDO    <= 1'b0;
            LISTO       <= 1'b0;
            DISPENSANDO <= 1'b0;
        end else begin
            state       <= state_d;
            req_q       <= req;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
            SALDO       <= saldo_d;
            VALIDO      <= valido_d;
            INVALIDO    <= invalido_d;
            LISTO       <= listo_d;
            DISPENSANDO <= disp_d;
        end
    end

    contador_billetes #(
        .CNT_W    (BAL_W),
        .BILL_GAP (BILL_GAP)
    ) u_pacer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_count (cnt_q),
        .fire       (fire),
        .gap_tick   (gap_tick),
        .billete    (BILLETE),
        .last_bill  (last_bill),
        .gap_last   (gap_last)
    );

endmodule

// File: tb/tb_cajero_dispensador.sv
// Directed testbench for cajero_dispensador with default parameters.
module tb_cajero_dispensador;

    logic        clk = 1'b0;
    logic        reset;
    logic        OPCION_1, OPCION_2, OPCION_3, OPCION_4, OPCION_5;
    logic        CARGAR;
    logic [15:0] SALDO_IN;
    logic        VALIDO, INVALIDO, BILLETE, DISPENSANDO, LISTO;
    logic [15:0] SALDO;

    int n_checks = 0;
    int n_errors = 0;

    cajero_dispensador dut (
        .clk         (clk),
        .reset       (reset),
        .OPCION_1    (OPCION_1),
        .OPCION_2    (OPCION_2),
        .OPCION_3    (OPCION_3),
        .OPCION_4    (OPCION_4),
        .OPCION_5    (OPCION_5),
        .CARGAR      (CARGAR),
        .SALDO_IN    (SALDO_IN),
        .VALIDO      (VALIDO),
        .INVALIDO    (INVALIDO),
        .BILLETE     (BILLETE),
        .DISPENSANDO (DISPENSANDO),
        .LISTO       (LISTO),
        .SALDO       (SALDO)
    );

    always #5 clk = ~clk;

    // Cycle counter: number of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge.
    int   n_bill = 0, n_val = 0, n_inv = 0, n_listo = 0;
    int   val_cyc = 0, inv_cyc = 0, first_bill_cyc = 0, listo_cyc = 0;
    int   prev_bill_cyc = 0, gap_err = 0;
    logic have_prev = 1'b0;
    logic dis_at_val = 1'b0, dis_at_listo = 1'b1;
    always @(negedge clk) begin
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            if (BILLETE) begin
                n_bill++;
                if (have_prev) begin
                    if (cyc - prev_bill_cyc != 3) gap_err++;
                end else begin
                    first_bill_cyc = cyc;
                end
                have_prev     = 1'b1;
                prev_bill_cyc = cyc;
            end
            if (VALIDO) begin
                n_val++;
                val_cyc    = cyc;
                dis_at_val = DISPENSANDO;
            end
            if (INVALIDO) begin
                n_inv++;
                inv_cyc = cyc;
            end
            if (LISTO) begin
                n_listo++;
                listo_cyc    = cyc;
                dis_at_listo = DISPENSANDO;
                have_prev    = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        OPCION_1 = 1'b0; OPCION_2 = 1'b0; OPCION_3 = 1'b0;
        OPCION_4 = 1'b0; OPCION_5 = 1'b0;
        CARGAR   = 1'b0; SALDO_IN = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    // Bounded wait for the next LISTO pulse beyond snapshot value.
    task automatic wait_listo(input int snap);
        for (int i = 0; i < 100 && n_listo == snap; i++) tick(1);
        tick(1);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        n_checks++;
        if (SALDO !== 16'd1000 || VALIDO !== 1'b0 || INVALIDO !== 1'b0 ||
            BILLETE !== 1'b0 || DISPENSANDO !== 1'b0 || LISTO !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: SALDO=%0d V=%b I=%b B=%b D=%b L=%b, want 1000 and all 0",
                     SALDO, VALIDO, INVALIDO, BILLETE, DISPENSANDO, LISTO);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_valid_500();
        int k, sb, sv, si, sl;
        do_reset();
        sb = n_bill; sv = n_val; si = n_inv; sl = n_listo; k = cyc;
        OPCION_3 = 1'b1;
        wait_listo(sl);
        OPCION_3 = 1'b0;
        n_checks++;
        if (n_listo != sl + 1) begin
            n_errors++;
            $display("FAIL v500_listo_timeout: listo count %0d, want %0d", n_listo - sl, 1);
        end
        n_checks++;
        if (n_val != sv + 1 || val_cyc != k + 2) begin
            n_errors++;
            $display("FAIL v500_valido: count %0d at cycle %0d, want 1 at %0d", n_val - sv, val_cyc, k + 2);
        end
        n_checks++;
        if (SALDO !== 16'd500) begin
            n_errors++;
            $display("FAIL v500_saldo: got %0d want 500", SALDO);
        end
        n_checks++;
        if (n_bill != sb + 5 || first_bill_cyc != k + 3 || gap_err != 0) begin
            n_errors++;
            $display("FAIL v500_bills: count %0d first %0d gap_err %0d, want 5 first %0d gap_err 0",
                     n_bill - sb, first_bill_cyc, gap_err, k + 3);
        end
        n_checks++;
        if (listo_cyc - (k + 1) != 15) begin
            n_errors++;
            $display("FAIL v500_latency: edge-to-LISTO %0d cycles, want 15", listo_cyc - (k + 1));
        end
        n_checks++;
        if (dis_at_val !== 1'b1 || dis_at_listo !== 1'b0 || n_inv != si) begin
            n_errors++;
            $display("FAIL v500_dispensando: at VALIDO %b at LISTO %b inv %0d, want 1 0 0",
                     dis_at_val, dis_at_listo, n_inv - si);
        end
        tick(2);
    endtask

    task automatic test_over_balance();
        int k, sb, sv, si;
        do_reset();
        sb = n_bill; sv = n_val; si = n_inv; k = cyc;
        OPCION_5 = 1'b1;
        tick(6);
        OPCION_5 = 1'b0;
        n_checks++;
        if (n_inv != si + 1 || inv_cyc != k + 2) begin
            n_errors++;
            $display("FAIL over_invalido: count %0d at %0d, want 1 at %0d", n_inv - si, inv_cyc, k + 2);
        end
        n_checks++;
        if (SALDO !== 16'd1000 || n_bill != sb || n_val != sv || DISPENSANDO !== 1'b0) begin
            n_errors++;
            $display("FAIL over_nochange: SALDO %0d bills %0d val %0d D %b, want 1000 0 0 0",
                     SALDO, n_bill - sb, n_val - sv, DISPENSANDO);
        end
        tick(2);
    endtask

    task automatic test_exact_balance();
        int k, sb, si, sl;
        do_reset();
        sb = n_bill; sl = n_listo; k = cyc;
        OPCION_4 = 1'b1;
        wait_listo(sl);
        OPCION_4 = 1'b0;
        n_checks++;
        if (SALDO !== 16'd0 || n_bill != sb + 10 || listo_cyc != k + 31) begin
            n_errors++;
            $display("FAIL exact_accept: SALDO %0d bills %0d listo %0d, want 0 10 %0d",
                     SALDO, n_bill - sb, listo_cyc, k + 31);
        end
        tick(2);
        si = n_inv; sb = n_bill; k = cyc;
        OPCION_1 = 1'b1;
        tick(6);
        OPCION_1 = 1'b0;
        n_checks++;
        if (n_inv != si + 1 || inv_cyc != k + 2 || SALDO !== 16'd0 || n_bill != sb) begin
            n_errors++;
            $display("FAIL zero_reject: inv %0d at %0d SALDO %0d bills %0d, want 1 at %0d 0 0",
                     n_inv - si, inv_cyc, SALDO, n_bill - sb, k + 2);
        end
        tick(2);
    endtask

    task automatic test_multi_hot();
        int k, sv, si, sb;
        do_reset();
        sv = n_val; si = n_inv; sb = n_bill; k = cyc;
        OPCION_1 = 1'b1;
        OPCION_2 = 1'b1;
        tick(6);
        OPCION_1 = 1'b0;
        OPCION_2 = 1'b0;
        n_checks++;
        if (n_inv != si + 1 || inv_cyc != k + 1) begin
            n_errors++;
            $display("FAIL multi_invalido: count %0d at %0d, want 1 at %0d", n_inv - si, inv_cyc, k + 1);
        end
        n_checks++;
        if (n_val != sv || n_bill != sb || SALDO !== 16'd1000 || DISPENSANDO !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_nochange: val %0d bills %0d SALDO %0d D %b, want 0 0 1000 0",
                     n_val - sv, n_bill - sb, SALDO, DISPENSANDO);
        end
        tick(2);
    endtask

    task automatic test_held_option();
        int sb, sv, si, sl;
        do_reset();
        sb = n_bill; sv = n_val; si = n_inv; sl = n_listo;
        OPCION_2 = 1'b1;
        for (int i = 0; i < 20 && n_bill == sb; i++) tick(1);
        OPCION_1 = 1'b1;
        wait_listo(sl);
        tick(6);
        n_checks++;
        if (n_bill != sb + 2 || n_val != sv + 1 || n_inv != si || SALDO !== 16'd800) begin
            n_errors++;
            $display("FAIL held_option: bills %0d val %0d inv %0d SALDO %0d, want 2 1 0 800",
                     n_bill - sb, n_val - sv, n_inv - si, SALDO);
        end
        OPCION_1 = 1'b0;
        OPCION_2 = 1'b0;
        tick(2);
    endtask

    task automatic test_cargar();
        int k, si, sl;
        do_reset();
        CARGAR   = 1'b1;
        SALDO_IN = 16'd300;
        tick(1);
        CARGAR   = 1'b0;
        n_checks++;
        if (SALDO !== 16'd300) begin
            n_errors++;
            $display("FAIL cargar_load: got %0d want 300", SALDO);
        end
        si = n_inv; k = cyc;
        OPCION_3 = 1'b1;
        tick(6);
        OPCION_3 = 1'b0;
        n_checks++;
        if (n_inv != si + 1 || inv_cyc != k + 2 || SALDO !== 16'd300) begin
            n_errors++;
            $display("FAIL cargar_reject: inv %0d at %0d SALDO %0d, want 1 at %0d 300",
                     n_inv - si, inv_cyc, SALDO, k + 2);
        end
        tick(2);
        // Request edge together with CARGAR: the request wins.
        sl = n_listo;
        CARGAR   = 1'b1;
        SALDO_IN = 16'd50;
        OPCION_1 = 1'b1;
        tick(1);
        CARGAR   = 1'b0;
        wait_listo(sl);
        OPCION_1 = 1'b0;
        n_checks++;
        if (SALDO !== 16'd200 || n_listo != sl + 1) begin
            n_errors++;
            $display("FAIL cargar_vs_req: SALDO %0d listo %0d, want 200 1", SALDO, n_listo - sl);
        end
        tick(2);
    endtask

    task automatic test_reset_gap();
        int sb;
        do_reset();
        sb = n_bill;
        OPCION_3 = 1'b1;
        for (int i = 0; i < 20 && n_bill == sb; i++) tick(1);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        n_checks++;
        if (SALDO !== 16'd1000 || VALIDO !== 1'b0 || INVALIDO !== 1'b0 ||
            BILLETE !== 1'b0 || DISPENSANDO !== 1'b0 || LISTO !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_gap_state: SALDO=%0d V=%b I=%b B=%b D=%b L=%b, want 1000 and all 0",
                     SALDO, VALIDO, INVALIDO, BILLETE, DISPENSANDO, LISTO);
        end
        OPCION_3 = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(10);
        n_checks++;
        if (n_bill != sb + 1 || SALDO !== 16'd1000) begin
            n_errors++;
            $display("FAIL reset_gap_abort: bills %0d SALDO %0d, want 1 1000", n_bill - sb, SALDO);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_valid_500();
        test_over_balance();
        test_exact_balance();
        test_multi_hot();
        test_held_option();
        test_cargar();
        test_reset_gap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
